alu_arb: RTL and testbench
==========================

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 The clocking SHALL be one clock and the reset SHALL be asynchronous and active-low.
REQ-002 Ports SHALL be:
- clk, input, 1, sole clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req0_valid, input, 1, requester 0 presents an operation.
- req0_ready, output, 1, requester 0 operation accepted this cycle.
- req0_ra, input, 32, operand A.
- req0_rb, input, 32, operand B.
- req0_arith_mode, input, 1, ALU arith mode.
- req0_logic_alt, input, 1, ALU logic/shift alt select.
- req0_funct3, input, 3, ALU funct3.
- req0_op_sel, input, 2, result select: 0 arith, 1 logic, 2 shift, 3 compare.
- req1_*, same set as req0_*, requester 1.
- resp_valid, output, 1, response register holds a result.
- resp_ready, input, 1, consumer accepts the response.
- resp_id, output, 1, index of the originating requester.
- resp_data, output, 32, result.

Function
REQ-003 The block SHALL contain one alu instance, fed only from the stage-1 operand register.
REQ-004 The pipeline SHALL have two stages: stage 1 (operand/control/id register, s1_v) and stage 2 (response register, s2_v); resp_valid = s2_v.
- s2 loads when s1_v and (!s2_v or resp_ready); s2_v clears when resp_ready and no load.
- s1 accepts when !s1_v or s1 advances into s2 in the same cycle.
REQ-005 At most one of req0_ready/req1_ready SHALL be high per cycle; readyN is high only when reqN_valid is high, N is granted, and s1 can accept; readyN is combinational.
REQ-006 Arbitration: with one valid requester, grant that requester; with both valid, grant per REQ-013; last_grant updates only on an accepted transfer.
REQ-007 Latency: a request accepted at edge N SHALL give resp_valid high after edge N+1 when the response path is free; sustained throughput one result per cycle with resp_ready held high.
REQ-008 resp_data: op_sel 0 arith_out, 1 logic_out, 2 shifter_out, 3 {31'b0, cmp}, where cmp = arith_unsigned_compare if funct3[0] else arith_signed_compare.
REQ-009 While resp_valid is high and resp_ready is low, resp_data and resp_id SHALL hold stable, and stage 1 SHALL hold if full.
REQ-010 Requester inputs SHALL be sampled only on an accepted transfer; inputs of a non-granted requester are ignored.

Reset
REQ-011 On rst_n low: s1_v=0, s2_v=0, resp_id=0, resp_data=0, last_grant=1, req0_ready=req1_ready=0; takes effect immediately, without a clock edge.
REQ-012 Operations in flight at reset assertion SHALL be discarded and produce no response after reset release.

Configuration
REQ-013 Macro ALU_ARB_RR_EN:
- Defined: round-robin; on a tie, grant the requester other than last_grant.
- Undefined: fixed priority, requester 0 always wins ties; last_grant register is absent.

Verification
REQ-014 Single op: req0 ra=5, rb=3, op_sel=0, arith_mode=add, resp_ready=1 -> resp_valid after 2 edges, resp_data=8, resp_id=0.
REQ-015 Tie with ALU_ARB_RR_EN: both valid every cycle for 4 cycles -> grant order 0,1,0,1; without the macro -> 0,0,0,0.
REQ-016 Backpressure: resp_ready=0 with 3 ops offered -> 2 accepted (s1 and s2 full), readyN=0 afterwards, resp_data stable; resp_ready=1 -> drains in order.
REQ-017 Compare: op_sel=3, ra=32'hFFFFFFFF, rb=1, funct3[0]=0 -> resp_data=1 (signed less-than); funct3[0]=1 -> resp_data=0.
REQ-018 Reset mid-operation: rst_n low with s1_v=s2_v=1 -> resp_valid=0 immediately; no response emitted after release.

Source files
------------

// File: rtl/alu_arb_if.sv
// alu_arb_if: request/response bundle between two ALU requesters, the
// arbitrated ALU pipeline and the response consumer.
// slave  - seen by the alu_arb block.
// master - seen by the requesters/consumer side (testbench or system).
interface alu_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_ra;
  logic [31:0] req0_rb;
  logic        req0_arith_mode;
  logic        req0_logic_alt;
  logic [2:0]  req0_funct3;
  logic [1:0]  req0_op_sel;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_ra;
  logic [31:0] req1_rb;
  logic        req1_arith_mode;
  logic        req1_logic_alt;
  logic [2:0]  req1_funct3;
  logic [1:0]  req1_op_sel;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_data;

  modport slave (
    input  req0_valid, req0_ra, req0_rb, req0_arith_mode, req0_logic_alt,
           req0_funct3, req0_op_sel,
    output req0_ready,
    input  req1_valid, req1_ra, req1_rb, req1_arith_mode, req1_logic_alt,
           req1_funct3, req1_op_sel,
    output req1_ready,
    output resp_valid, resp_id, resp_data,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_ra, req0_rb, req0_arith_mode, req0_logic_alt,
           req0_funct3, req0_op_sel,
    input  req0_ready,
    output req1_valid, req1_ra, req1_rb, req1_arith_mode, req1_logic_alt,
           req1_funct3, req1_op_sel,
    input  req1_ready,
    input  resp_valid, resp_id, resp_data,
    output resp_ready
  );
endinterface

// File: rtl/alu_arb.sv
// alu_arb: two requesters share one ALU through a two-stage pipeline.
// Stage 1 holds the granted operands/control/id, stage 2 is the response
// register. Requester ready is combinational from valid, grant and space.
// Config macro ALU_ARB_RR_EN: when defined, ties are resolved round-robin
// against last_grant; when undefined, requester 0 always wins a tie and
// no last_grant register exists.
// ALU encoding:
//   arith : arith_mode 0 = a+b, 1 = a-b
//   logic : funct3[1:0] 11 = and, 10 = or, else xor; logic_alt inverts
//   shift : funct3[2] 0 = sll, 1 = srl (logic_alt 1 = sra); amount b[4:0]
//   compare outputs: signed and unsigned a<b

module alu_arb_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        arith_mode,
  input  logic        logic_alt,
  input  logic [2:0]  funct3,
  output logic [31:0] arith_out,
  output logic [31:0] logic_out,
  output logic [31:0] shifter_out,
  output logic        arith_signed_compare,
  output logic        arith_unsigned_compare
);
  // Pure combinational ALU datapath.
  always_comb begin
    arith_out              = 32'd0;
    logic_out              = 32'd0;
    shifter_out            = 32'd0;
    arith_signed_compare   = 1'b0;
    arith_unsigned_compare = 1'b0;

    if (arith_mode) begin
      arith_out = a - b;
    end else begin
      arith_out = a + b;
    end

    case (funct3[1:0])
      2'b11:   logic_out = a & b;
      2'b10:   logic_out = a | b;
      default: logic_out = a ^ b;
    endcase
    if (logic_alt) begin
      logic_out = ~logic_out;
    end else begin
      logic_out = logic_out;
    end

    if (!funct3[2]) begin
      shifter_out = a << b[4:0];
    end else if (logic_alt) begin
      shifter_out = $unsigned($signed(a) >>> b[4:0]);
    end else begin
      shifter_out = a >> b[4:0];
    end

    arith_signed_compare   = ($signed(a) < $signed(b));
    arith_unsigned_compare = (a < b);
  end
endmodule

module alu_arb (
  input  logic       clk,
  input  logic       rst_n,
  alu_arb_if.slave   bus
);
  // Stage 1 (operands/control/id) and stage 2 (response) state.
  logic        s1_v_q,   s1_v_d;
  logic [31:0] s1_ra_q,  s1_ra_d;
  logic [31:0] s1_rb_q,  s1_rb_d;
  logic        s1_am_q,  s1_am_d;
  logic        s1_la_q,  s1_la_d;
  logic [2:0]  s1_f3_q,  s1_f3_d;
  logic [1:0]  s1_os_q,  s1_os_d;
  logic        s1_id_q,  s1_id_d;
  logic        s2_v_q,   s2_v_d;
  logic [31:0] s2_data_q, s2_data_d;
  logic        s2_id_q,  s2_id_d;
`ifdef ALU_ARB_RR_EN
  logic        last_grant_q, last_grant_d;
`endif

  logic        grant1_s;
  logic        s1_adv_s;
  logic        s1_free_s;
  logic        accept_s;
  logic [31:0] result_s;

  logic [31:0] arith_out_s;
  logic [31:0] logic_out_s;
  logic [31:0] shifter_out_s;
  logic        cmp_signed_s;
  logic        cmp_unsigned_s;

  // The only ALU, fed exclusively from the stage-1 register.
  alu_arb_alu u_alu (
    .a                      (s1_ra_q),
    .b                      (s1_rb_q),
    .arith_mode             (s1_am_q),
    .logic_alt              (s1_la_q),
    .funct3                 (s1_f3_q),
    .arith_out              (arith_out_s),
    .logic_out              (logic_out_s),
    .shifter_out            (shifter_out_s),
    .arith_signed_compare   (cmp_signed_s),
    .arith_unsigned_compare (cmp_unsigned_s)
  );

  // Arbitration: single valid requester wins; ties go to the policy.
  always_comb begin
    grant1_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_RR_EN
      grant1_s = ~last_grant_q;
`else
      grant1_s = 1'b0;
`endif
    end else if (bus.req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant1_s = 1'b0;
    end
  end

  // Flow control: stage 1 can take a new op when empty or draining now.
  // rst_n gates acceptance so ready is low while reset is asserted.
  always_comb begin
    s1_adv_s  = s1_v_q & (~s2_v_q | bus.resp_ready);
    s1_free_s = ~s1_v_q | s1_adv_s;
    accept_s  = rst_n & s1_free_s & (bus.req0_valid | bus.req1_valid);
  end

  assign bus.req0_ready = accept_s & ~grant1_s;
  assign bus.req1_ready = accept_s &  grant1_s;

  // Result select from the ALU outputs.
  always_comb begin
    result_s = 32'd0;
    case (s1_os_q)
      2'd0:    result_s = arith_out_s;
      2'd1:    result_s = logic_out_s;
      2'd2:    result_s = shifter_out_s;
      2'd3:    result_s = {31'd0, (s1_f3_q[0] ? cmp_unsigned_s : cmp_signed_s)};
      default: result_s = 32'd0;
    endcase
  end

  // Next-state for both stages; requester fields captured only on accept.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_ra_d   = s1_ra_q;
    s1_rb_d   = s1_rb_q;
    s1_am_d   = s1_am_q;
    s1_la_d   = s1_la_q;
    s1_f3_d   = s1_f3_q;
    s1_os_d   = s1_os_q;
    s1_id_d   = s1_id_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_id_d   = s2_id_q;
`ifdef ALU_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    if (accept_s) begin
      s1_v_d = 1'b1;
      s1_id_d = grant1_s;
      if (grant1_s) begin
        s1_ra_d = bus.req1_ra;
        s1_rb_d = bus.req1_rb;
        s1_am_d = bus.req1_arith_mode;
        s1_la_d = bus.req1_logic_alt;
        s1_f3_d = bus.req1_funct3;
        s1_os_d = bus.req1_op_sel;
      end else begin
        s1_ra_d = bus.req0_ra;
        s1_rb_d = bus.req0_rb;
        s1_am_d = bus.req0_arith_mode;
        s1_la_d = bus.req0_logic_alt;
        s1_f3_d = bus.req0_funct3;
        s1_os_d = bus.req0_op_sel;
      end
`ifdef ALU_ARB_RR_EN
      last_grant_d = grant1_s;
`endif
    end else if (s1_adv_s) begin
      s1_v_d = 1'b0;
    end else begin
      s1_v_d = s1_v_q;
    end

    if (s1_adv_s) begin
      s2_v_d    = 1'b1;
      s2_data_d = result_s;
      s2_id_d   = s1_id_q;
    end else if (bus.resp_ready) begin
      s2_v_d = 1'b0;
    end else begin
      s2_v_d = s2_v_q;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_ra_q   <= 32'd0;
      s1_rb_q   <= 32'd0;
      s1_am_q   <= 1'b0;
      s1_la_q   <= 1'b0;
      s1_f3_q   <= 3'd0;
      s1_os_q   <= 2'd0;
      s1_id_q   <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_data_q <= 32'd0;
      s2_id_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      s1_v_q    <= s1_v_d;
      s1_ra_q   <= s1_ra_d;
      s1_rb_q   <= s1_rb_d;
      s1_am_q   <= s1_am_d;
      s1_la_q   <= s1_la_d;
      s1_f3_q   <= s1_f3_d;
      s1_os_q   <= s1_os_d;
      s1_id_q   <= s1_id_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_id_q   <= s2_id_d;
`ifdef ALU_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.resp_valid = s2_v_q;
  assign bus.resp_data  = s2_data_q;
  assign bus.resp_id    = s2_id_q;
endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: scoreboard bench for alu_arb. Expected responses are pushed
// when a transfer is seen accepted and popped when a response handshakes.
module tb_alu_arb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arb_if bus ();

  alu_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU, written independently of the RTL structure.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic am, input logic la,
                                          input logic [2:0] f3, input logic [1:0] os);
    logic [31:0] r;
    int sh;
    sh = int'(b[4:0]);
    if (os == 2'd0) begin
      r = am ? (a - b) : (a + b);
    end else if (os == 2'd1) begin
      if (f3[1:0] == 2'b11)      r = a & b;
      else if (f3[1:0] == 2'b10) r = a | b;
      else                       r = a ^ b;
      if (la) r = ~r;
    end else if (os == 2'd2) begin
      if (!f3[2])   r = a << sh;
      else if (!la) r = a >> sh;
      else          r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
    end else begin
      if (f3[0]) r = {31'd0, (a < b)};
      else       r = {31'd0, ((a[31] != b[31]) ? a[31] : (a < b))};
    end
    return r;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n === 1'b1) begin
      check_val("ready_onehot", {63'd0, bus.req0_ready & bus.req1_ready}, 64'd0);
      if (bus.req0_ready) begin
        check_val("ready0_needs_valid", {63'd0, bus.req0_valid}, 64'd1);
        e.id = 1'b0;
        e.data = ref_alu(bus.req0_ra, bus.req0_rb, bus.req0_arith_mode, bus.req0_logic_alt,
                         bus.req0_funct3, bus.req0_op_sel);
        exp_q.push_back(e);
      end
      if (bus.req1_ready) begin
        check_val("ready1_needs_valid", {63'd0, bus.req1_valid}, 64'd1);
        e.id = 1'b1;
        e.data = ref_alu(bus.req1_ra, bus.req1_rb, bus.req1_arith_mode, bus.req1_logic_alt,
                         bus.req1_funct3, bus.req1_op_sel);
        exp_q.push_back(e);
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) begin
          check_val("resp_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("resp_id", {63'd0, bus.resp_id}, {63'd0, e.id});
          check_val("resp_data", {32'd0, bus.resp_data}, {32'd0, e.data});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic am, input logic la, input logic [2:0] f3, input logic [1:0] os);
    if (n == 0) begin
      bus.req0_valid = 1'b1; bus.req0_ra = a; bus.req0_rb = b;
      bus.req0_arith_mode = am; bus.req0_logic_alt = la;
      bus.req0_funct3 = f3; bus.req0_op_sel = os;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_ra = a; bus.req1_rb = b;
      bus.req1_arith_mode = am; bus.req1_logic_alt = la;
      bus.req1_funct3 = f3; bus.req1_op_sel = os;
    end
  endtask

  task automatic clr_req(input int n);
    if (n == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  // Wait (bounded) for requester n to be accepted; returns #1 after the edge.
  task automatic wait_acc(input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (n == 0) ? bus.req0_ready : bus.req1_ready;
      tick();
    end
    if (!ok) check_val("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input int n, input logic [31:0] a, input logic [31:0] b,
                      input logic am, input logic la, input logic [2:0] f3, input logic [1:0] os);
    logic ok;
    set_req(n, a, b, am, la, f3, os);
    wait_acc(n, ok);
    clr_req(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          g[4];
    int          exp_g[4];
    int          acc;
    logic        a0, a1, ok;
    logic [31:0] d0;
    logic        id0;

    bus.req0_valid = 1'b0; bus.req0_ra = 32'd0; bus.req0_rb = 32'd0;
    bus.req0_arith_mode = 1'b0; bus.req0_logic_alt = 1'b0;
    bus.req0_funct3 = 3'd0; bus.req0_op_sel = 2'd0;
    bus.req1_valid = 1'b0; bus.req1_ra = 32'd0; bus.req1_rb = 32'd0;
    bus.req1_arith_mode = 1'b0; bus.req1_logic_alt = 1'b0;
    bus.req1_funct3 = 3'd0; bus.req1_op_sel = 2'd0;
    bus.resp_ready = 1'b1;

    // Reset state, with a requester already valid.
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    #1;
    check_val("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check_val("rst_resp_id", {63'd0, bus.resp_id}, 64'd0);
    check_val("rst_resp_data", {32'd0, bus.resp_data}, 64'd0);
    check_val("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    check_val("rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
    bus.req0_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Tie: both valid for four cycles straight after reset.
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      set_req(0, 32'd100 + 32'(i), 32'd1, 1'b0, 1'b0, 3'd0, 2'd0);
      set_req(1, 32'd200 + 32'(i), 32'd2, 1'b1, 1'b0, 3'd0, 2'd0);
      @(negedge clk);
      g[i] = bus.req1_ready ? 1 : (bus.req0_ready ? 0 : 2);
      tick();
    end
    clr_req(0); clr_req(1);
    for (int i = 0; i < 4; i++) check_val($sformatf("tie_grant%0d", i), 64'(g[i]), 64'(exp_g[i]));
    repeat (4) tick();

    // Single add: 5+3 on requester 0, two-edge latency.
    send(0, 32'd5, 32'd3, 1'b0, 1'b0, 3'd0, 2'd0);
    check_val("lat_edge1_valid", {63'd0, bus.resp_valid}, 64'd0);
    tick();
    check_val("lat_edge2_valid", {63'd0, bus.resp_valid}, 64'd1);
    check_val("single_data", {32'd0, bus.resp_data}, 64'd8);
    check_val("single_id", {63'd0, bus.resp_id}, 64'd0);
    repeat (2) tick();

    // Compare: signed then unsigned on -1 vs 1.
    send(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 3'd0, 2'd3);
    tick();
    check_val("cmp_signed", {32'd0, bus.resp_data}, 64'd1);
    send(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 3'd1, 2'd3);
    tick();
    check_val("cmp_unsigned", {32'd0, bus.resp_data}, 64'd0);
    repeat (2) tick();

    // Backpressure: three ops offered, only two fit.
    bus.resp_ready = 1'b0;
    acc = 0;
    set_req(0, 32'd10, 32'd1, 1'b0, 1'b0, 3'd0, 2'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a0 = bus.req0_ready;
      tick();
      if (a0) begin
        acc++;
        set_req(0, 32'd10 * 32'(acc + 1), 32'd1, 1'b0, 1'b0, 3'd0, 2'd0);
      end
    end
    check_val("bp_accepted", 64'(acc), 64'd2);
    @(negedge clk);
    check_val("bp_ready0_low", {63'd0, bus.req0_ready}, 64'd0);
    check_val("bp_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
    d0 = bus.resp_data;
    id0 = bus.resp_id;
    check_val("bp_head_data", {32'd0, d0}, 64'd11);
    tick(); tick();
    check_val("bp_data_stable", {32'd0, bus.resp_data}, {32'd0, d0});
    check_val("bp_id_stable", {63'd0, bus.resp_id}, {63'd0, id0});
    bus.resp_ready = 1'b1;
    wait_acc(0, ok);
    clr_req(0);
    repeat (4) tick();

    // Random mixed traffic with random backpressure.
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      a0 = bus.req0_ready;
      a1 = bus.req1_ready;
      tick();
      if (a0 || !bus.req0_valid) begin
        set_req(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        bus.req0_valid = 1'($urandom_range(0, 1));
      end
      if (a1 || !bus.req1_valid) begin
        set_req(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        bus.req1_valid = 1'($urandom_range(0, 1));
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
    end
    clr_req(0); clr_req(1);
    bus.resp_ready = 1'b1;
    repeat (5) tick();
    check_val("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset with both stages full.
    bus.resp_ready = 1'b0;
    send(0, 32'd7, 32'd7, 1'b0, 1'b0, 3'd0, 2'd0);
    send(1, 32'd9, 32'd9, 1'b0, 1'b0, 3'd0, 2'd0);
    check_val("mid_pre_valid", {63'd0, bus.resp_valid}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", {63'd0, bus.resp_valid}, 64'd0);
    exp_q.delete();
    bus.resp_ready = 1'b1;
    set_req(0, 32'd1, 32'd1, 1'b0, 1'b0, 3'd0, 2'd0);
    #1;
    check_val("mid_rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    clr_req(0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val($sformatf("post_rst_quiet%0d", i), {63'd0, bus.resp_valid}, 64'd0);
    end
    check_val("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
